// File: rtl/usb_pkg.sv
// Shared types for the USB host transaction sequencer.
package usb_pkg;

  // Packet identifiers placed on the transmit pipe.
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  // Transaction sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_TOKEN_WAIT,
    ST_DATA,
    ST_DATA_WAIT,
    ST_RX_HS,
    ST_RX_DATA,
    ST_ACK,
    ST_ACK_WAIT,
    ST_DONE
  } txn_state_t;

endpackage

// File: rtl/usb_timeout_timer.sv
// Response timer: counts waiting cycles while enabled, flags the last allowed cycle.
module usb_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  // expired covers the final waiting cycle so the FSM can act on it at the next edge.
  assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Next count: clear wins, then count up, holding at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token / DATA0 / ACK launch, response
// watch, timeout and retry for one OUT or IN request at a time.
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE       | ready for a request
// TOKEN      | launch OUT/IN token (one-cycle out_pktready)
// TOKEN_WAIT | token in flight, wait out_sent
// DATA       | launch DATA0 with OUT payload
// DATA_WAIT  | DATA0 in flight, wait out_sent
// RX_HS      | OUT: listen for handshake, timer running
// RX_DATA    | IN: listen for data packet, timer running
// ACK        | IN: launch ACK for received data
// ACK_WAIT   | ACK in flight, wait out_sent
// DONE       | one-cycle completion pulse
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 8
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_endp,
  input  logic [63:0] req_data,
  output logic        done,
  output logic        success,
  output logic [63:0] rsp_data,
  output logic [3:0]  out_pid,
  output logic [6:0]  out_addr,
  output logic [3:0]  out_endp,
  output logic [63:0] out_data,
  output logic        out_pktready,
  input  logic        out_sent,
  output logic        writing,
  input  logic        in_pktready,
  input  logic [63:0] in_data,
  input  logic        in_error,
  input  logic        in_ack,
  input  logic        in_nak
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  txn_state_t    state_q, state_d;
  logic          read_q, read_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [63:0]   data_q, data_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          success_q, success_d;
  logic [63:0]   rsp_q, rsp_d;

  logic [3:0]    pid_c;
  logic          launch_c;
  logic          writing_c;
  logic          fail_c;
  logic          tmo_clear, tmo_en, tmo_expired;

  usb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_L  (rst_L),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  // Next-state, launch and response evaluation.
  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    retry_d   = retry_q;
    success_d = success_q;
    rsp_d     = rsp_q;
    pid_c     = 4'b0000;
    launch_c  = 1'b0;
    writing_c = 1'b0;
    fail_c    = 1'b0;
    tmo_en    = 1'b0;
    tmo_clear = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          read_d    = req_read;
          addr_d    = req_addr;
          endp_d    = req_endp;
          data_d    = req_data;
          retry_d   = '0;
          success_d = 1'b0;
          rsp_d     = '0;
          state_d   = ST_TOKEN;
        end
      end
      ST_TOKEN: begin
        pid_c     = read_q ? PID_IN : PID_OUT;
        writing_c = 1'b1;
        launch_c  = 1'b1;
        state_d   = ST_TOKEN_WAIT;
      end
      ST_TOKEN_WAIT: begin
        pid_c     = read_q ? PID_IN : PID_OUT;
        writing_c = 1'b1;
        if (out_sent) state_d = read_q ? ST_RX_DATA : ST_DATA;
      end
      ST_DATA: begin
        pid_c     = PID_DATA0;
        writing_c = 1'b1;
        launch_c  = 1'b1;
        state_d   = ST_DATA_WAIT;
      end
      ST_DATA_WAIT: begin
        pid_c     = PID_DATA0;
        writing_c = 1'b1;
        if (out_sent) state_d = ST_RX_HS;
      end
      ST_RX_HS: begin
        tmo_en    = 1'b1;
        tmo_clear = 1'b0;
        // Any event other than a clean lone ACK is a failed attempt.
        if (in_ack && !in_nak && !in_error && !in_pktready) begin
          success_d = 1'b1;
          state_d   = ST_DONE;
        end else if (in_ack || in_nak || in_error || in_pktready || tmo_expired) begin
          fail_c = 1'b1;
        end
      end
      ST_RX_DATA: begin
        tmo_en    = 1'b1;
        tmo_clear = 1'b0;
        if (in_pktready && !in_error) begin
          rsp_d   = in_data;
          state_d = ST_ACK;
        end else if (in_nak || in_error || tmo_expired) begin
          fail_c = 1'b1;
        end
      end
      ST_ACK: begin
        pid_c     = PID_ACK;
        writing_c = 1'b1;
        launch_c  = 1'b1;
        state_d   = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        pid_c     = PID_ACK;
        writing_c = 1'b1;
        if (out_sent) begin
          success_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A failed attempt resends the whole transaction until retries run out.
    if (fail_c) begin
      if (retry_q == RW'(MAX_RETRY)) begin
        state_d = ST_DONE;
      end else begin
        retry_d = retry_q + RW'(1);
        state_d = ST_TOKEN;
      end
    end
  end

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= ST_IDLE;
      read_q    <= 1'b0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      retry_q   <= '0;
      success_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      data_q    <= data_d;
      retry_q   <= retry_d;
      success_q <= success_d;
      rsp_q     <= rsp_d;
    end
  end

  // Transmit fields come from latched request registers, so they stay put
  // from launch until out_sent.
  assign req_ready    = (state_q == ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign success      = success_q;
  assign rsp_data     = rsp_q;
  assign out_pid      = pid_c;
  assign out_addr     = addr_q;
  assign out_endp     = endp_q;
  assign out_data     = data_q;
  assign out_pktready = launch_c;
  assign writing      = writing_c;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
module tb_usb_txn_ctrl;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        req_valid, req_ready, req_read;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [63:0] req_data;
  logic        done, success;
  logic [63:0] rsp_data;
  logic [3:0]  out_pid;
  logic [6:0]  out_addr;
  logic [3:0]  out_endp;
  logic [63:0] out_data;
  logic        out_pktready, out_sent, writing;
  logic        in_pktready, in_error, in_ack, in_nak;
  logic [63:0] in_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_launch = 0;
  int n_ack_launch = 0;
  int n_done = 0;

  usb_txn_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_L(rst_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
    .done(done), .success(success), .rsp_data(rsp_data),
    .out_pid(out_pid), .out_addr(out_addr), .out_endp(out_endp),
    .out_data(out_data), .out_pktready(out_pktready), .out_sent(out_sent),
    .writing(writing), .in_pktready(in_pktready), .in_data(in_data),
    .in_error(in_error), .in_ack(in_ack), .in_nak(in_nak)
  );

  always #5 clk = ~clk;

  // Launch / completion monitor.
  always @(posedge clk) begin
    if (out_pktready === 1'b1) begin
      n_launch = n_launch + 1;
      if (out_pid === 4'b0010) n_ack_launch = n_ack_launch + 1;
    end
    if (done === 1'b1) n_done = n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic rd, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    req_read = rd; req_addr = a; req_endp = e; req_data = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_launch(input string tag, output logic [3:0] pid, output logic wr);
    int n = 0;
    while (out_pktready !== 1'b1 && n < 100) begin tick(); n++; end
    check({tag, "_launch"}, {63'd0, out_pktready}, 64'd1);
    pid = out_pid;
    wr  = writing;
  endtask

  task automatic sent_after(input int n);
    repeat (n) tick();
    out_sent = 1'b1;
    tick();
    out_sent = 1'b0;
  endtask

  task automatic pulse_rx(input logic a, input logic k, input logic er,
                          input logic pk, input logic [63:0] d);
    in_ack = a; in_nak = k; in_error = er; in_pktready = pk; in_data = d;
    tick();
    in_ack = 0; in_nak = 0; in_error = 0; in_pktready = 0; in_data = '0;
  endtask

  task automatic wait_done(input string tag, output logic succ);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin tick(); n++; end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    succ = success;
  endtask

  initial begin
    logic [3:0] pid;
    logic       wr;
    logic       succ;
    int         base, base_ack, base_done;

    rst_L = 0; req_valid = 0; req_read = 0; req_addr = '0; req_endp = '0;
    req_data = '0; out_sent = 0; in_pktready = 0; in_data = '0;
    in_error = 0; in_ack = 0; in_nak = 0;
    repeat (3) tick();

    // Reset values
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_success", {63'd0, success}, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_pktready", {63'd0, out_pktready}, 64'd0);
    check("rst_pid", {60'd0, out_pid}, 64'd0);
    check("rst_addr", {57'd0, out_addr}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_writing", {63'd0, writing}, 64'd0);
    rst_L = 1;
    tick();

    // T1: OUT with ACK after 10 cycles
    base = n_launch;
    start_req(0, 7'h05, 4'h2, 64'hDEADBEEF_01234567);
    wait_launch("t1_tok", pid, wr);
    check("t1_tok_pid", {60'd0, pid}, 64'h1);
    check("t1_tok_wr", {63'd0, wr}, 64'd1);
    check("t1_addr", {57'd0, out_addr}, 64'h05);
    check("t1_endp", {60'd0, out_endp}, 64'h2);
    check("t1_req_ready_busy", {63'd0, req_ready}, 64'd0);
    sent_after(2);
    wait_launch("t1_dat", pid, wr);
    check("t1_dat_pid", {60'd0, pid}, 64'h3);
    check("t1_dat_data", out_data, 64'hDEADBEEF_01234567);
    check("t1_dat_wr", {63'd0, wr}, 64'd1);
    sent_after(1);
    check("t1_rx_writing", {63'd0, writing}, 64'd0);
    repeat (9) tick();
    pulse_rx(1, 0, 0, 0, '0);
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_success", {63'd0, success}, 64'd1);
    tick();
    check("t1_done_one_cycle", {63'd0, done}, 64'd0);
    check("t1_ready_after", {63'd0, req_ready}, 64'd1);
    check("t1_success_held", {63'd0, success}, 64'd1);
    check("t1_launches", n_launch - base, 64'd2);

    // T2: OUT, NAK twice then ACK
    base = n_launch;
    start_req(0, 7'h11, 4'h3, 64'h0000_0000_CAFE_F00D);
    for (int a = 0; a < 3; a++) begin
      wait_launch("t2_tok", pid, wr);
      check("t2_tok_pid", {60'd0, pid}, 64'h1);
      sent_after(1);
      wait_launch("t2_dat", pid, wr);
      check("t2_dat_pid", {60'd0, pid}, 64'h3);
      sent_after(1);
      repeat (2) tick();
      if (a < 2) pulse_rx(0, 1, 0, 0, '0);
      else       pulse_rx(1, 0, 0, 0, '0);
    end
    wait_done("t2", succ);
    check("t2_success", {63'd0, succ}, 64'd1);
    check("t2_launches", n_launch - base, 64'd6);
    tick();

    // T3: IN with data, ACK sent
    base = n_launch;
    start_req(1, 7'h22, 4'h1, 64'd0);
    check("t3_rsp_cleared", rsp_data, 64'd0);
    wait_launch("t3_tok", pid, wr);
    check("t3_tok_pid", {60'd0, pid}, 64'h9);
    sent_after(1);
    check("t3_rx_writing", {63'd0, writing}, 64'd0);
    repeat (3) tick();
    pulse_rx(0, 0, 0, 1, 64'h1122334455667788);
    wait_launch("t3_ack", pid, wr);
    check("t3_ack_pid", {60'd0, pid}, 64'h2);
    check("t3_ack_wr", {63'd0, wr}, 64'd1);
    check("t3_no_done_before_sent", {63'd0, done}, 64'd0);
    sent_after(2);
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_success", {63'd0, success}, 64'd1);
    check("t3_rsp", rsp_data, 64'h1122334455667788);
    check("t3_launches", n_launch - base, 64'd2);
    tick();

    // T4: IN with no response: 16-cycle timeout, 3 attempts, fail
    base = n_launch;
    base_ack = n_ack_launch;
    start_req(1, 7'h33, 4'h4, 64'd0);
    for (int a = 0; a < 3; a++) begin
      wait_launch("t4_tok", pid, wr);
      check("t4_tok_pid", {60'd0, pid}, 64'h9);
      sent_after(1);
      repeat (15) tick();
      check("t4_still_waiting", {62'd0, out_pktready, done}, 64'd0);
      tick();
      if (a < 2) check("t4_retry_launch", {63'd0, out_pktready}, 64'd1);
      else       check("t4_final_done", {63'd0, done}, 64'd1);
    end
    check("t4_success", {63'd0, success}, 64'd0);
    check("t4_launches", n_launch - base, 64'd3);
    check("t4_no_ack", n_ack_launch - base_ack, 64'd0);
    tick();

    // T5a: ACK+NAK together is a failure, retry then ACK
    base = n_launch;
    start_req(0, 7'h44, 4'h5, 64'h5555_AAAA_5555_AAAA);
    wait_launch("t5a_tok", pid, wr);
    sent_after(1);
    wait_launch("t5a_dat", pid, wr);
    sent_after(1);
    tick();
    pulse_rx(1, 1, 0, 0, '0);
    wait_launch("t5a_tok2", pid, wr);
    check("t5a_retry_pid", {60'd0, pid}, 64'h1);
    sent_after(1);
    wait_launch("t5a_dat2", pid, wr);
    sent_after(1);
    tick();
    pulse_rx(1, 0, 0, 0, '0);
    wait_done("t5a", succ);
    check("t5a_success", {63'd0, succ}, 64'd1);
    check("t5a_launches", n_launch - base, 64'd4);
    tick();

    // T5b: ACK on the timeout-expiry cycle wins
    base = n_launch;
    start_req(0, 7'h45, 4'h6, 64'h0123_4567_89AB_CDEF);
    wait_launch("t5b_tok", pid, wr);
    sent_after(1);
    wait_launch("t5b_dat", pid, wr);
    sent_after(1);
    repeat (15) tick();
    pulse_rx(1, 0, 0, 0, '0);
    check("t5b_done", {63'd0, done}, 64'd1);
    check("t5b_success", {63'd0, success}, 64'd1);
    check("t5b_launches", n_launch - base, 64'd2);
    tick();

    // T6: reset during DATA_WAIT aborts with no done, then a clean request
    base_done = n_done;
    start_req(0, 7'h66, 4'h7, 64'hFFFF_0000_FFFF_0000);
    wait_launch("t6_tok", pid, wr);
    sent_after(1);
    wait_launch("t6_dat", pid, wr);
    tick();
    rst_L = 0;
    tick();
    check("t6_req_ready", {63'd0, req_ready}, 64'd1);
    check("t6_writing", {63'd0, writing}, 64'd0);
    check("t6_pid", {60'd0, out_pid}, 64'd0);
    check("t6_data", out_data, 64'd0);
    check("t6_pktready", {63'd0, out_pktready}, 64'd0);
    check("t6_success", {63'd0, success}, 64'd0);
    rst_L = 1;
    repeat (3) tick();
    check("t6_no_done", n_done - base_done, 64'd0);
    base = n_launch;
    start_req(0, 7'h67, 4'h8, 64'h0F0F_0F0F_0F0F_0F0F);
    wait_launch("t6_tok2", pid, wr);
    check("t6_tok2_pid", {60'd0, pid}, 64'h1);
    check("t6_addr2", {57'd0, out_addr}, 64'h67);
    sent_after(1);
    wait_launch("t6_dat2", pid, wr);
    check("t6_dat2_data", out_data, 64'h0F0F_0F0F_0F0F_0F0F);
    sent_after(1);
    repeat (4) tick();
    pulse_rx(1, 0, 0, 0, '0);
    wait_done("t6", succ);
    check("t6_success2", {63'd0, succ}, 64'd1);
    check("t6_launches2", n_launch - base, 64'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
